// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Shared register-index width, counter width and FSM state encodings for the
// hazard stall controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int REG_W    = 5;
    localparam int MD_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BR_WAIT = 2'b01,
        ST_MD_BUSY = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_reg_match.sv
// ============================================================================
// Module : hazard_reg_match
// Flags when a valid, nonzero destination register is read by the ID stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_reg_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] dest,
    input  logic             valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             usesRt,
    output logic             match
);

    logic w_nonzero;

    // r0 is hardwired to zero, so a write to it never creates a dependency
    assign w_nonzero = (dest != '0);
    assign match     = valid && w_nonzero && ((dest == rs) || (usesRt && (dest == rt)));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module : hazard_stall_controller
// Pipeline stall/flush control for load-use, branch-operand and multi-cycle
// mult/div hazards. Define HAZARD_STALL_COUNT_EN to add the StallCount port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_MulDiv,
    input  logic             BranchTaken,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [REG_W-1:0] EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic [REG_W-1:0] MEM_WriteReg,
    output logic             IF_ID_Write,
    output logic             PC_Hold,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0]      StallCount
`endif
);

    localparam logic [MD_CNT_W-1:0] c_md_load = MD_CNT_W'(MULDIV_LATENCY - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [MD_CNT_W-1:0] r_md_count;
    logic [MD_CNT_W-1:0] w_next_count;
    logic                w_stall;
    logic                w_flush;
    logic                w_ex_load_match;
    logic                w_ex_alu_match;
    logic                w_mem_load_match;
    logic                w_data_hazard;

    hazard_reg_match u_ex_load_match (
        .dest   (EX_WriteReg),
        .valid  (EX_MemRead),
        .rs     (ID_Rs),
        .rt     (ID_Rt),
        .usesRt (ID_UsesRt),
        .match  (w_ex_load_match)
    );

    hazard_reg_match u_ex_alu_match (
        .dest   (EX_WriteReg),
        .valid  (EX_RegWrite & ~EX_MemRead),
        .rs     (ID_Rs),
        .rt     (ID_Rt),
        .usesRt (ID_UsesRt),
        .match  (w_ex_alu_match)
    );

    hazard_reg_match u_mem_load_match (
        .dest   (MEM_WriteReg),
        .valid  (MEM_MemRead),
        .rs     (ID_Rs),
        .rt     (ID_Rt),
        .usesRt (ID_UsesRt),
        .match  (w_mem_load_match)
    );

    // Non-branch consumers get ALU/MEM results by forwarding; only branches
    // resolved in ID must wait on them.
    assign w_data_hazard = w_ex_load_match | (ID_Branch & (w_ex_alu_match | w_mem_load_match));

    always_comb begin
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_next_state = ST_IDLE;
        w_next_count = r_md_count;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_data_hazard | ID_MulDiv;
                w_flush = ID_Branch & BranchTaken & ~w_stall;
                if (ID_Branch && w_ex_load_match) begin
                    w_next_state = ST_BR_WAIT;
                end else if (!w_data_hazard && ID_MulDiv) begin
                    w_next_state = ST_MD_BUSY;
                    w_next_count = c_md_load;
                end
            end
            ST_BR_WAIT: begin
                w_stall = 1'b1;
            end
            ST_MD_BUSY: begin
                w_stall = 1'b1;
                if (r_md_count <= MD_CNT_W'(1)) begin
                    w_next_count = '0;
                end else begin
                    w_next_state = ST_MD_BUSY;
                    w_next_count = r_md_count - MD_CNT_W'(1);
                end
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_md_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_md_count <= w_next_count;
        end
    end

    assign IF_ID_Write  = w_stall & ~Reset;
    assign PC_Hold      = w_stall & ~Reset;
    assign ID_EX_Bubble = w_stall & ~Reset;
    assign IF_ID_Flush  = w_flush & ~Reset;

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_count <= '0;
        end else if (w_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign StallCount = Reset ? 32'd0 : r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module : tb_hazard_stall_controller
// Directed self-checking bench for hazard_stall_controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

    logic       Clk;
    logic       Reset;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRt;
    logic       ID_Branch;
    logic       ID_MulDiv;
    logic       BranchTaken;
    logic       EX_MemRead;
    logic       EX_RegWrite;
    logic [4:0] EX_WriteReg;
    logic       MEM_MemRead;
    logic [4:0] MEM_WriteReg;
    logic       IF_ID_Write;
    logic       PC_Hold;
    logic       ID_EX_Bubble;
    logic       IF_ID_Flush;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] StallCount;
    logic [31:0] exp_cnt = 32'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_controller #(.MULDIV_LATENCY(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .ID_Branch    (ID_Branch),
        .ID_MulDiv    (ID_MulDiv),
        .BranchTaken  (BranchTaken),
        .EX_MemRead   (EX_MemRead),
        .EX_RegWrite  (EX_RegWrite),
        .EX_WriteReg  (EX_WriteReg),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_WriteReg (MEM_WriteReg),
        .IF_ID_Write  (IF_ID_Write),
        .PC_Hold      (PC_Hold),
        .ID_EX_Bubble (ID_EX_Bubble),
        .IF_ID_Flush  (IF_ID_Flush)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .StallCount   (StallCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clr();
        ID_Rs        = 5'd0;
        ID_Rt        = 5'd0;
        ID_UsesRt    = 1'b0;
        ID_Branch    = 1'b0;
        ID_MulDiv    = 1'b0;
        BranchTaken  = 1'b0;
        EX_MemRead   = 1'b0;
        EX_RegWrite  = 1'b0;
        EX_WriteReg  = 5'd0;
        MEM_MemRead  = 1'b0;
        MEM_WriteReg = 5'd0;
    endtask

    // Inputs are applied just after a negedge; outputs are sampled 1 time unit
    // later, then one full cycle elapses before the next step.
    task automatic chk(input string tag, input logic es, input logic ef);
        logic [3:0] obs;
        logic [3:0] expv;
        #1;
        obs  = {IF_ID_Write, PC_Hold, ID_EX_Bubble, IF_ID_Flush};
        expv = {es, es, es, ef};
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed stall/hold/bubble/flush=%b expected=%b", tag, obs, expv);
        end
`ifdef HAZARD_STALL_COUNT_EN
        n_cmp++;
        assert (StallCount === exp_cnt) else begin
            n_err++;
            $error("FAIL %s_cnt: observed StallCount=%h expected=%h", tag, StallCount, exp_cnt);
        end
        if (Reset) exp_cnt = 32'd0;
        else if (es) exp_cnt = exp_cnt + 32'd1;
`endif
        @(negedge Clk);
    endtask

    initial begin
        clr();
        Reset = 1'b1;
        ID_Branch = 1'b1; BranchTaken = 1'b1; ID_MulDiv = 1'b1;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        @(negedge Clk);
        chk("reset_outputs_a", 1'b0, 1'b0);
        chk("reset_outputs_b", 1'b0, 1'b0);

        Reset = 1'b0;
        clr();
        chk("idle_quiet", 1'b0, 1'b0);

        // load-use on rs, then bubble in EX
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        chk("loaduse_rs", 1'b1, 1'b0);
        EX_MemRead = 1'b0;
        chk("loaduse_bubble", 1'b0, 1'b0);

        // load-use on rt only counts when rt is read
        clr();
        EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 1'b1;
        chk("loaduse_rt", 1'b1, 1'b0);
        ID_UsesRt = 1'b0;
        chk("loaduse_rt_unused", 1'b0, 1'b0);

        // branch after load: two stall cycles, then the branch resolves
        clr();
        ID_Branch = 1'b1; BranchTaken = 1'b1;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
        chk("brload_c1", 1'b1, 1'b0);
        EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
        MEM_MemRead = 1'b1; MEM_WriteReg = 5'd9;
        chk("brload_brwait", 1'b1, 1'b0);
        MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
        chk("brload_resolve", 1'b0, 1'b1);

        // branch after ALU op: one stall cycle only
        clr();
        ID_Branch = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = 5'd3; ID_Rs = 5'd3;
        chk("bralu_stall", 1'b1, 1'b0);
        clr();
        chk("bralu_after", 1'b0, 1'b0);

        // non-branch ALU dependency is forwarded
        EX_RegWrite = 1'b1; EX_WriteReg = 5'd3; ID_Rs = 5'd3;
        chk("alu_forward", 1'b0, 1'b0);

        // branch on a load in MEM
        clr();
        ID_Branch = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd7; ID_Rs = 5'd7;
        chk("brmem_stall", 1'b1, 1'b0);
        clr();
        chk("brmem_after", 1'b0, 1'b0);

        // taken branch with no hazard flushes; r0 never matches
        ID_Branch = 1'b1; BranchTaken = 1'b1;
        chk("br_taken_flush", 1'b0, 1'b1);
        EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0;
        chk("br_taken_r0", 1'b0, 1'b1);

        // data hazard outranks mult/div start; nothing latched
        clr();
        ID_MulDiv = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd2; ID_Rs = 5'd2;
        chk("md_vs_loaduse", 1'b1, 1'b0);
        clr();
        chk("md_vs_loaduse_after", 1'b0, 1'b0);

        // mult/div: four stall cycles, hazards ignored while busy
        ID_MulDiv = 1'b1;
        chk("md_c1", 1'b1, 1'b0);
        ID_MulDiv = 1'b0; ID_Branch = 1'b1; BranchTaken = 1'b1;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd4; ID_Rs = 5'd4;
        chk("md_c2", 1'b1, 1'b0);
        chk("md_c3", 1'b1, 1'b0);
        chk("md_c4", 1'b1, 1'b0);
        clr();
        chk("md_done", 1'b0, 1'b0);

        // reset in the second busy cycle aborts the operation
        ID_MulDiv = 1'b1;
        chk("mdr_c1", 1'b1, 1'b0);
        ID_MulDiv = 1'b0;
        chk("mdr_busy1", 1'b1, 1'b0);
        Reset = 1'b1;
        chk("mdr_reset", 1'b0, 1'b0);
        Reset = 1'b0;
        chk("mdr_idle", 1'b0, 1'b0);

`ifdef HAZARD_STALL_COUNT_EN
        // counter wraps from all-ones to zero
        force dut.r_stall_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_count;
        exp_cnt = 32'hFFFF_FFFF;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8;
        #2;
        chk("cnt_wrap_stall", 1'b1, 1'b0);
        clr();
        chk("cnt_wrap_zero", 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 The block SHALL have parameter MULDIV_LATENCY, default 4, meaning the total stall cycles for a multi-cycle multiply/divide (legal range 2..15).
REQ-002 The port list SHALL be:
  Clk  in  1  clock; all state updates on posedge.
  Reset  in  1  synchronous, active-high.
  ID_Rs  in  5  source register rs of the instruction in ID.
  ID_Rt  in  5  source register rt of the instruction in ID.
  ID_UsesRt  in  1  ID instruction reads rt.
  ID_Branch  in  1  ID instruction is a branch resolved in ID.
  ID_MulDiv  in  1  ID instruction is multi-cycle mult/div.
  BranchTaken  in  1  branch in ID resolves taken.
  EX_MemRead  in  1  EX instruction is a load.
  EX_RegWrite  in  1  EX instruction writes a register.
  EX_WriteReg  in  5  EX destination register.
  MEM_MemRead  in  1  MEM instruction is a load.
  MEM_WriteReg  in  5  MEM destination register.
  IF_ID_Write  out  1  1 = hold the IF/ID register (stall), 0 = load.
  PC_Hold  out  1  1 = hold PC.
  ID_EX_Bubble  out  1  1 = zero control fields entering ID/EX.
  IF_ID_Flush  out  1  1 = load a NOP into IF/ID.
  StallCount  out  32  stall-cycle counter (only with HAZARD_STALL_COUNT_EN).

Function
REQ-003 "Stall" SHALL mean IF_ID_Write=1, PC_Hold=1, ID_EX_Bubble=1 in the same cycle; the three SHALL always be equal.
REQ-004 Stall outputs SHALL be combinational from current state and inputs (same-cycle effect), with no added latency.
REQ-005 A register match SHALL require a nonzero destination; register 0 never matches.
REQ-006 Load-use: EX_MemRead and EX_WriteReg equal to ID_Rs, or to ID_Rt with ID_UsesRt -> stall this cycle; no state change.
REQ-007 Branch-ALU: ID_Branch and EX_RegWrite, not EX_MemRead, EX_WriteReg matches ID_Rs/ID_Rt -> stall this cycle only.
REQ-008 Branch-load: ID_Branch and EX_MemRead with a match -> stall this cycle, next state BR_WAIT; BR_WAIT stalls exactly one further cycle, then IDLE.
REQ-009 Branch-MEM-load: ID_Branch and MEM_MemRead and MEM_WriteReg matches -> stall this cycle only.
REQ-010 MulDiv: ID_MulDiv in IDLE with no other hazard -> stall; next state MD_BUSY; counter loaded with MULDIV_LATENCY-1.
REQ-011 MD_BUSY SHALL stall every cycle and decrement the counter; on counter value 1 it SHALL return to IDLE, giving exactly MULDIV_LATENCY consecutive stall cycles.
REQ-012 Inside BR_WAIT or MD_BUSY, new hazard inputs SHALL be ignored until IDLE is re-entered.
REQ-013 Priority in IDLE SHALL be: load-use/branch data hazards > MulDiv start > flush.
REQ-014 IF_ID_Flush SHALL equal BranchTaken and ID_Branch in an IDLE, non-stall cycle, else 0.
REQ-015 States SHALL be IDLE, BR_WAIT, MD_BUSY (2-bit encoding); unused encoding SHALL go to IDLE with no stall.

Reset
REQ-016 Reset SHALL force state IDLE, counter 0, StallCount 0 at the next posedge, aborting any BR_WAIT/MD_BUSY.
REQ-017 While Reset is high all outputs SHALL be 0 regardless of inputs.

Configuration
REQ-018 With macro HAZARD_STALL_COUNT_EN defined, StallCount SHALL increment by 1 each non-reset cycle in which stall is asserted, wrapping 0xFFFFFFFF -> 0.
REQ-019 Without HAZARD_STALL_COUNT_EN, the StallCount port and its register SHALL be absent.

Structure
REQ-020 State encodings and the register-index width (5) SHALL live in shared package hazard_pkg.
REQ-021 The match logic SHALL be a sub-module hazard_reg_match (dest, valid, rs, rt, usesRt -> match), instantiated per comparison; the FSM stays in the top.

Verification
REQ-022 EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> stall 1 cycle, next cycle (bubble in EX) no stall.
REQ-023 ID_Branch=1, EX_MemRead=1, EX_WriteReg=9, ID_Rt=9, ID_UsesRt=1 -> stall 2 cycles (IDLE->BR_WAIT->IDLE), flush 0 in both.
REQ-024 ID_MulDiv=1, MULDIV_LATENCY=4 -> stall exactly 4 cycles, then 0; hazards raised mid-busy ignored.
REQ-025 ID_Branch=1, BranchTaken=1, no hazard -> IF_ID_Flush=1 one cycle, stall 0; same with EX_WriteReg=0 matching rs 0 -> still no stall.
REQ-026 Reset asserted in 2nd MD_BUSY cycle -> outputs 0 immediately, IDLE next cycle, StallCount 0 (with macro); StallCount preset 0xFFFFFFFF plus one stall -> 0.
